mac_job_ctrl: RTL
=================

# mac_job_ctrl

Parametrised job controller for the MAC accelerator: a generalised successor to the fixed two-context, six-coefficient MAC control path. Holds a staging parameter set written over a simple register port, queues up to N_CONTEXT committed jobs, and sequences each job as start → iteration stream → wait-for-engine → completion event to the issuing core. Coefficients, shift and mode are latched per job, so they stay stable while software reprograms the next job. Sits between the peripheral interconnect and the MAC engine/streamer.

## Interface
- N_CORES, 2, number of cores receiving completion events
- N_CONTEXT, 2, depth of committed-job queue (≥1)
- N_COEFF, 6, number of coefficient registers
- COEFF_WIDTH, 16, coefficient width (≤32, low bits of written word)
- CNT_WIDTH, 12, iteration-count width
- ID_WIDTH, 10, config transaction ID width
- clk_i  in  1  clock
- rst_i  in  1  Reset. One clock; reset is asynchronous and active-high.
- clear_i  in  1  synchronous soft clear, same effect as reset
- cfg_req_i  in  1  config request
- cfg_gnt_o  out  1  grant; equals cfg_req_i (combinational)
- cfg_wen_i  in  1  1 = write, 0 = read
- cfg_add_i  in  8  word address
- cfg_data_i  in  32  write data
- cfg_id_i  in  ID_WIDTH  transaction ID; low bits select issuing core
- cfg_r_valid_o  out  1  read/write response valid, one cycle after grant
- cfg_r_data_o  out  32  read data (0 for writes)
- cfg_r_id_o  out  ID_WIDTH  echoed ID
- eng_start_o  out  1  one-cycle job start pulse
- iter_valid_o  out  1  iteration descriptor valid
- iter_ready_i  in  1  engine accepts iteration
- iter_idx_o  out  CNT_WIDTH  current iteration index
- iter_last_o  out  1  final iteration of job
- eng_done_i  in  1  engine finished job
- coeff_o  out  N_COEFF×COEFF_WIDTH  latched coefficients
- shift_o  out  5  latched shift
- simple_mul_o  out  1  latched mode bit
- len_o  out  CNT_WIDTH+1  latched LEN_ITER+1
- busy_o  out  1  FSM not IDLE
- evt_o  out  N_CORES  one-cycle completion pulse

## Operation
- Address map (word): 0 TRIGGER (W), 1 ACQUIRE (R), 2 STATUS (R), 3 PERF (R), 8 NB_ITER, 9 LEN_ITER, 10 SHIFT_SIMPLEMUL ([20:16] shift, [0] simple_mul), 12+k COEFF_k for k<N_COEFF. Unmapped: writes ignored, reads 0.
- Param writes always update the staging set; staging readable back.
- TRIGGER write: if queue not full, push {staging, core = cfg_id_i mod N_CORES}; else drop and set sticky STATUS[31] overflow.
- ACQUIRE read: number of free queue slots; 0xFFFF_FFFF when full.
- STATUS: [0] busy, [15:8] queued count, [31] overflow (cleared only by reset/clear).
- NB_ITER and LEN_ITER hold value minus one; job issues NB_ITER+1 iterations; counts truncated to CNT_WIDTH.
- FSM: IDLE → LOAD when queue non-empty; LOAD (pop head into active regs) → START; START (eng_start_o=1) → RUN; RUN issues iter_valid_o, advancing iter_idx_o on each valid&ready; handshake with iter_last_o → WAIT; WAIT → DONE on eng_done_i; DONE (evt_o[core]=1) → LOAD if queue non-empty, else IDLE.
- eng_done_i outside WAIT ignored. iter_valid_o held until ready; idx/last stable while stalled.
- Push and pop in same cycle on full queue: both occur, count unchanged, no overflow.
- Latched outputs hold last job's values after DONE until next LOAD.

## Timing
- Reset/clear: all outputs 0, queue empty, staging and active regs 0, FSM IDLE.
- TRIGGER write at cycle T with FSM IDLE: LOAD at T+1, eng_start_o at T+2, iter_valid_o from T+3.
- Latched outputs update at end of LOAD (visible with eng_start_o).
- eng_done_i at cycle D in WAIT: evt_o at D+1; next job's eng_start_o at D+3 if queued.
- Reset mid-job: asynchronous, outputs 0 immediately; no event issued.

## Configuration
- MAC_JOB_CTRL_PERF_CNT_EN defined: 32-bit counter of cycles from START to DONE inclusive for the last completed job, readable at PERF, saturating. Undefined: counter absent, PERF reads 0.

## Test plan
- Write NB_ITER=3, COEFF_0=0x1234, TRIGGER from id 1 → eng_start_o 2 cycles later, coeff_o[0]=0x1234, 4 iterations idx 0..3, last on idx 3, eng_done_i → evt_o=2'b10 next cycle.
- Hold iter_ready_i low 5 cycles mid-job → iter_idx_o and iter_valid_o stable; total iterations still NB_ITER+1.
- Three TRIGGERs with N_CONTEXT=2 while busy → third dropped, STATUS[31]=1, ACQUIRE reads 0xFFFF_FFFF.
- Rewrite COEFF_0=0xBEEF during a job → coeff_o unchanged until next LOAD.
- Assert rst_i during RUN → all outputs 0 same cycle, no evt_o, queue empty.
- With MAC_JOB_CTRL_PERF_CNT_EN, NB_ITER=0, ready always high, done 1 cycle into WAIT → PERF reads 4.

Source files
------------

// File: rtl/mac_job_ctrl.sv
// mac_job_ctrl: queued MAC job controller with register port, iteration sequencer and per-core completion events.
// Define MAC_JOB_CTRL_PERF_CNT_EN to add a saturating START-to-DONE cycle counter readable at PERF.
module mac_job_ctrl #(
    parameter int N_CORES     = 2,
    parameter int N_CONTEXT   = 2,
    parameter int N_COEFF     = 6,
    parameter int COEFF_WIDTH = 16,
    parameter int CNT_WIDTH   = 12,
    parameter int ID_WIDTH    = 10
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    input  logic                           cfg_req_i,
    output logic                           cfg_gnt_o,
    input  logic                           cfg_wen_i,
    input  logic [7:0]                     cfg_add_i,
    input  logic [31:0]                    cfg_data_i,
    input  logic [ID_WIDTH-1:0]            cfg_id_i,
    output logic                           cfg_r_valid_o,
    output logic [31:0]                    cfg_r_data_o,
    output logic [ID_WIDTH-1:0]            cfg_r_id_o,
    output logic                           eng_start_o,
    output logic                           iter_valid_o,
    input  logic                           iter_ready_i,
    output logic [CNT_WIDTH-1:0]           iter_idx_o,
    output logic                           iter_last_o,
    input  logic                           eng_done_i,
    output logic [N_COEFF*COEFF_WIDTH-1:0] coeff_o,
    output logic [4:0]                     shift_o,
    output logic                           simple_mul_o,
    output logic [CNT_WIDTH:0]             len_o,
    output logic                           busy_o,
    output logic [N_CORES-1:0]             evt_o
);
    localparam int CORE_W = N_CORES > 1 ? $clog2(N_CORES) : 1;
    localparam int PTR_W  = N_CONTEXT > 1 ? $clog2(N_CONTEXT) : 1;
    localparam int QC_W   = $clog2(N_CONTEXT + 1);

    // len is stored already incremented so len_o reads straight from the active set
    typedef struct packed {
        logic [N_COEFF-1:0][COEFF_WIDTH-1:0] coeff;
        logic [4:0]                          shift;
        logic                                simple_mul;
        logic [CNT_WIDTH-1:0]                nb_iter;
        logic [CNT_WIDTH:0]                  len;
        logic [CORE_W-1:0]                   core;
    } job_t;

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, WAIT, DONE} state_t;

    state_t                              state;
    job_t                                q [N_CONTEXT];
    job_t                                head, push_job, act;
    logic [N_COEFF-1:0][COEFF_WIDTH-1:0] stg_coeff;
    logic [4:0]                          stg_shift;
    logic                                stg_mul;
    logic [CNT_WIDTH-1:0]                stg_nb, stg_len;
    logic [PTR_W-1:0]                    rd_ptr, wr_ptr;
    logic [QC_W-1:0]                     q_cnt;
    logic                                q_full, trig, push, pop, pending, ovf, unused_data;
    logic [31:0]                         rdata, perf;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return p == PTR_W'(N_CONTEXT - 1) ? '0 : p + 1'b1;
    endfunction

    assign cfg_gnt_o    = cfg_req_i;
    assign trig         = cfg_req_i && cfg_wen_i && cfg_add_i == 8'd0;
    assign pop          = state == LOAD;
    assign q_full       = q_cnt == QC_W'(N_CONTEXT);
    assign push         = trig && (!q_full || pop);
    assign pending      = q_cnt != '0 || push;
    assign head         = q[rd_ptr];
    assign coeff_o      = act.coeff;
    assign shift_o      = act.shift;
    assign simple_mul_o = act.simple_mul;
    assign len_o        = act.len;
    assign unused_data  = ^cfg_data_i;
    assign push_job     = '{coeff: stg_coeff, shift: stg_shift, simple_mul: stg_mul, nb_iter: stg_nb,
                            len: {1'b0, stg_len} + 1'b1, core: CORE_W'(cfg_id_i % N_CORES)};

    always_comb begin
        rdata = '0;
        case (cfg_add_i)
            8'd1:    rdata = q_full ? '1 : 32'(N_CONTEXT) - 32'(q_cnt);
            8'd2:    rdata = {ovf, 15'd0, 8'(q_cnt), 7'd0, busy_o};
            8'd3:    rdata = perf;
            8'd8:    rdata = 32'(stg_nb);
            8'd9:    rdata = 32'(stg_len);
            8'd10:   rdata = {11'd0, stg_shift, 15'd0, stg_mul};
            default: for (int k = 0; k < N_COEFF; k++) if (cfg_add_i == 8'(12 + k)) rdata = 32'(stg_coeff[k]);
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            {cfg_r_valid_o, cfg_r_data_o, cfg_r_id_o} <= '0;
            {stg_coeff, stg_shift, stg_mul, stg_nb, stg_len} <= '0;
        end else if (clear_i) begin
            {cfg_r_valid_o, cfg_r_data_o, cfg_r_id_o} <= '0;
            {stg_coeff, stg_shift, stg_mul, stg_nb, stg_len} <= '0;
        end else begin
            cfg_r_valid_o <= cfg_req_i;
            cfg_r_data_o  <= cfg_req_i && !cfg_wen_i ? rdata : '0;
            cfg_r_id_o    <= cfg_req_i ? cfg_id_i : '0;
            if (cfg_req_i && cfg_wen_i) begin
                if (cfg_add_i == 8'd8) stg_nb <= cfg_data_i[CNT_WIDTH-1:0];
                if (cfg_add_i == 8'd9) stg_len <= cfg_data_i[CNT_WIDTH-1:0];
                if (cfg_add_i == 8'd10) {stg_shift, stg_mul} <= {cfg_data_i[20:16], cfg_data_i[0]};
                for (int k = 0; k < N_COEFF; k++)
                    if (cfg_add_i == 8'(12 + k)) stg_coeff[k] <= cfg_data_i[COEFF_WIDTH-1:0];
            end
        end
    end

    // a trigger on a full queue still lands when the head is popped in the same cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            {rd_ptr, wr_ptr, q_cnt, ovf} <= '0;
        end else if (clear_i) begin
            {rd_ptr, wr_ptr, q_cnt, ovf} <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            q_cnt <= q_cnt + QC_W'(push) - QC_W'(pop);
            if (trig && !push) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) if (push) q[wr_ptr] <= push_job;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            act <= '0;
            {eng_start_o, iter_valid_o, iter_idx_o, iter_last_o, busy_o, evt_o} <= '0;
        end else if (clear_i) begin
            state <= IDLE;
            act <= '0;
            {eng_start_o, iter_valid_o, iter_idx_o, iter_last_o, busy_o, evt_o} <= '0;
        end else begin
            eng_start_o <= 1'b0;
            evt_o <= '0;
            case (state)
                IDLE: if (pending) begin
                    state <= LOAD;
                    busy_o <= 1'b1;
                end
                LOAD: begin
                    act <= head;
                    iter_idx_o <= '0;
                    eng_start_o <= 1'b1;
                    state <= START;
                end
                START: begin
                    iter_valid_o <= 1'b1;
                    iter_last_o <= act.nb_iter == '0;
                    state <= RUN;
                end
                RUN: if (iter_ready_i) begin
                    if (iter_last_o) begin
                        {iter_valid_o, iter_last_o} <= 2'b00;
                        state <= WAIT;
                    end else begin
                        iter_idx_o <= iter_idx_o + 1'b1;
                        iter_last_o <= iter_idx_o + 1'b1 == act.nb_iter;
                    end
                end
                WAIT: if (eng_done_i) begin
                    evt_o <= N_CORES'(1) << act.core;
                    state <= DONE;
                end
                DONE: begin
                    busy_o <= pending;
                    state <= pending ? LOAD : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAC_JOB_CTRL_PERF_CNT_EN
    logic [31:0] perf_run;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            {perf_run, perf} <= '0;
        end else if (clear_i) begin
            {perf_run, perf} <= '0;
        end else begin
            if (state == START) perf_run <= 32'd1;
            if (state == RUN || state == WAIT) perf_run <= &perf_run ? perf_run : perf_run + 1'b1;
            if (state == DONE) perf <= &perf_run ? perf_run : perf_run + 1'b1;
        end
    end
`else
    assign perf = '0;
`endif
endmodule
